// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: DIFF = A - B - Bin, LSB first, one bit per clock,
// built around a single full-subtractor cell and a registered borrow.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] DIFF,
    output logic             Bout
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    function automatic logic fs_diff(input logic a, input logic b, input logic bi);
        return a ^ b ^ bi;
    endfunction

    function automatic logic fs_borrow(input logic a, input logic b, input logic bi);
        return (~a & b) | (~(a ^ b) & bi);
    endfunction

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] res_sh_r;
    logic             brw_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] diff_r;
    logic             bout_r;

    logic             d_s;
    logic             brw_nxt_s;
    logic [WIDTH:0]   res_ext_s;
    logic [WIDTH-1:0] res_nxt_s;
    logic             last_bit_s;
    logic             accept_s;

    // Full-subtractor cell and the shifted-in result word
    always_comb begin
        d_s        = fs_diff(a_sh_r[0], b_sh_r[0], brw_r);
        brw_nxt_s  = fs_borrow(a_sh_r[0], b_sh_r[0], brw_r);
        res_ext_s  = {d_s, res_sh_r};
        res_nxt_s  = res_ext_s[WIDTH:1];
        last_bit_s = (cnt_r == CNT_LAST);
        accept_s   = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    end

    // Next-state decode; start is only honoured from IDLE or DONE
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_SHIFT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (last_bit_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (accept_s) begin
                    state_nxt_s = ST_SHIFT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand capture and per-bit shifting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_r   <= '0;
            b_sh_r   <= '0;
            res_sh_r <= '0;
            brw_r    <= 1'b0;
            cnt_r    <= '0;
        end else if (accept_s) begin
            a_sh_r   <= A;
            b_sh_r   <= B;
            res_sh_r <= '0;
            brw_r    <= Bin;
            cnt_r    <= '0;
        end else if (state_r == ST_SHIFT) begin
            a_sh_r   <= a_sh_r >> 1;
            b_sh_r   <= b_sh_r >> 1;
            res_sh_r <= res_nxt_s;
            brw_r    <= brw_nxt_s;
            // Saturate at the last index so WIDTH = 1 never wraps
            if (!last_bit_s) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end else begin
            a_sh_r   <= a_sh_r;
            b_sh_r   <= b_sh_r;
            res_sh_r <= res_sh_r;
            brw_r    <= brw_r;
            cnt_r    <= cnt_r;
        end
    end

    // Result commit; old result stays visible while the next one is built
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_r <= '0;
            bout_r <= 1'b0;
        end else if ((state_r == ST_SHIFT) && last_bit_s) begin
            diff_r <= res_nxt_s;
            bout_r <= brw_nxt_s;
        end else begin
            diff_r <= diff_r;
            bout_r <= bout_r;
        end
    end

    assign busy = (state_r == ST_SHIFT);
    assign done = (state_r == ST_DONE);
    assign DIFF = diff_r;
    assign Bout = bout_r;

endmodule
